issue_pair_ctrl: RTL and testbench
==================================

Name: issue_pair_ctrl

Overview:
- Dual-issue pairing and interlock controller in the ID stage, directly upstream of the two per-slot ID/EX pipeline registers (slot 0, slot 1).
- Inspects the decoded pair and the loads currently in EX, then drives the ID/EX control inputs: Stall, Flush, per-slot issue_select and Decode_Unicorn.
- Decides whether the pair issues together, is serialized over two cycles, or gets a load-use bubble.
- Latches mispredict flushes that arrive while the pipe is stalled and replays them.

Parameters:
- REG_AW, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  2  per-slot valid of decoded pair; bit0 = slot0 (older)
- id_rd0, id_rd1  in  REG_AW  destination index per slot
- id_rs1_0, id_rs2_0, id_rs1_1, id_rs2_1  in  REG_AW  source indices
- id_use_rs  in  4  {rs2_1, rs1_1, rs2_0, rs1_0} source-used flags
- id_wr  in  2  per-slot writes rd (rd==0 treated as no write)
- id_mem  in  2  per-slot load/store
- id_mdu  in  2  per-slot mul/div
- ex_load  in  2  per-EX-slot load valid
- ex_rd0, ex_rd1  in  REG_AW  EX-slot destination indices
- pipe_stall  in  1  global stall from MEM/WB
- mispredict  in  1  branch redirect from EX
- decode_unicorn  out  1  serialize-pair command to both ID/EX registers
- idex_stall  out  1  Stall to ID/EX
- idex_flush  out  1  Flush to ID/EX
- issue_select  out  2  per-slot flush qualifier
- ifid_hold  out  1  hold IF/ID and PC
- ifid_flush  out  1  clear IF/ID

Behaviour:
- Pair conflict (unicorn) when both id_valid bits are set and any of the following holds:
  - RAW: slot1 uses rs1/rs2 equal to id_rd0 with id_wr[0] and id_rd0 != 0.
  - WAW: both slots write the same nonzero rd.
  - Both id_mem set.
  - Both id_mdu set.
- FSM states:
  - PAIR: normal dual issue.
  - SPLIT1: second half of a serialized pair.
  - DRAIN: one cycle re-aligning the ID/EX toggle after a flush.
  - Reset state is PAIR.
- decode_unicorn = conflict in PAIR; forced 1 in SPLIT1 and DRAIN.
- PAIR, conflict, no stall and no bubble: ifid_hold=1, go to SPLIT1. Slot0 enters EX and slot1 gets a bubble.
- SPLIT1, no stall and no bubble: ifid_hold=0, go to PAIR. Slot1 enters EX and slot0 gets a bubble.
- Load-use bubble: ex_load[k] with ex_rd_k != 0 matching a used source of an issuing ID slot.
  - Issuing slots are both slots in PAIR and slot1 only in SPLIT1.
  - Response: idex_flush=1, ifid_hold=1, state unchanged. The ID/EX toggle does not advance on a flush cycle.
  - issue_select = 2'b11 in PAIR, 2'b10 in SPLIT1.
- Mispredict with pipe_stall=0:
  - idex_flush=1, issue_select=2'b11, ifid_flush=1.
  - Mispredict has priority over load-use.
  - Next state: DRAIN if the current state is SPLIT1, else PAIR.
- DRAIN: decode_unicorn=1 with flushed (invalid) ID, so the slot1 ID/EX register toggles back. Next state is PAIR. No hold.
- Mispredict with pipe_stall=1: set flush_pending. On the first cycle pipe_stall=0, replay as a mispredict and clear flush_pending.
- pipe_stall=1: idex_stall=1, ifid_hold=1, idex_flush=0, FSM frozen.
- pipe_stall has priority over everything except reset.
- idex_stall = pipe_stall only. Load-use and split never use Stall; they use Flush or hold.
- Reset: state=PAIR, flush_pending=0. All outputs are 0 during reset.
- Latency: outputs are combinational from inputs and state. The state registers update on the clk edge.

Test Plan:
- Independent pair: id_valid=11, rd0=5, slot1 srcs 6/7, no EX loads -> decode_unicorn=0, ifid_hold=0, idex_flush=0 every cycle.
- RAW pair: rd0=5, rs1_1=5 -> cycle0 unicorn=1, ifid_hold=1, state SPLIT1; cycle1 unicorn=1, hold=0; cycle2 back to PAIR.
- Load-use: ex_load[0]=1, ex_rd0=8, id_rs2_0=8 -> idex_flush=1, issue_select=11, ifid_hold=1 for one cycle; next cycle, with ex_load cleared, normal issue.
- Load-use in SPLIT1: RAW pair, then ex_load[0]=1, ex_rd0=3, id_rs1_1=3 -> issue_select=10, state stays SPLIT1 one extra cycle.
- Mispredict in SPLIT1 -> idex_flush=1, issue_select=11, ifid_flush=1; next cycle DRAIN with unicorn=1; then PAIR.
- Mispredict while pipe_stall=1 for 3 cycles -> no flush outputs during the stall; the cycle the stall drops gives idex_flush=1, ifid_flush=1. Separately, reset asserted in SPLIT1 -> state PAIR, all outputs 0.

Source files
------------

// File: rtl/issue_pair_if.sv
// Bundle between the ID-stage decode/hazard sources and the pairing controller.
// The controller sits on the slave side; the pipeline (or a bench) is the master.
interface issue_pair_if #(
    parameter int REG_AW = 5
);
    logic [1:0]        id_valid;
    logic [REG_AW-1:0] id_rd0;
    logic [REG_AW-1:0] id_rd1;
    logic [REG_AW-1:0] id_rs1_0;
    logic [REG_AW-1:0] id_rs2_0;
    logic [REG_AW-1:0] id_rs1_1;
    logic [REG_AW-1:0] id_rs2_1;
    logic [3:0]        id_use_rs;
    logic [1:0]        id_wr;
    logic [1:0]        id_mem;
    logic [1:0]        id_mdu;
    logic [1:0]        ex_load;
    logic [REG_AW-1:0] ex_rd0;
    logic [REG_AW-1:0] ex_rd1;
    logic              pipe_stall;
    logic              mispredict;
    logic              decode_unicorn;
    logic              idex_stall;
    logic              idex_flush;
    logic [1:0]        issue_select;
    logic              ifid_hold;
    logic              ifid_flush;

    modport master (
        output id_valid, id_rd0, id_rd1, id_rs1_0, id_rs2_0, id_rs1_1, id_rs2_1,
               id_use_rs, id_wr, id_mem, id_mdu, ex_load, ex_rd0, ex_rd1,
               pipe_stall, mispredict,
        input  decode_unicorn, idex_stall, idex_flush, issue_select,
               ifid_hold, ifid_flush
    );

    modport slave (
        input  id_valid, id_rd0, id_rd1, id_rs1_0, id_rs2_0, id_rs1_1, id_rs2_1,
               id_use_rs, id_wr, id_mem, id_mdu, ex_load, ex_rd0, ex_rd1,
               pipe_stall, mispredict,
        output decode_unicorn, idex_stall, idex_flush, issue_select,
               ifid_hold, ifid_flush
    );
endinterface

// File: rtl/issue_pair_ctrl.sv
// Dual-issue pairing / interlock controller: decides pair, serialize or load-use
// bubble for the ID/EX slot registers, and replays mispredicts hidden by a stall.
module issue_pair_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    issue_pair_if.slave bus
);
    typedef enum logic [1:0] {ST_PAIR, ST_SPLIT1, ST_DRAIN} state_t;

    state_t r_state;
    state_t w_next;
    logic   r_flush_pending;

    logic       w_raw, w_waw, w_conflict;
    logic       w_iss0, w_iss1, w_loaduse;
    logic       w_redirect;
    logic       w_unicorn, w_idex_flush, w_ifid_hold, w_ifid_flush;
    logic [1:0] w_issue_select;

    // True when rd is a used source of any slot currently allowed to issue.
    function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                     input logic iss0, input logic iss1);
        src_hit = (iss0 && bus.id_use_rs[0] && bus.id_rs1_0 == rd) ||
                  (iss0 && bus.id_use_rs[1] && bus.id_rs2_0 == rd) ||
                  (iss1 && bus.id_use_rs[2] && bus.id_rs1_1 == rd) ||
                  (iss1 && bus.id_use_rs[3] && bus.id_rs2_1 == rd);
    endfunction

    assign w_raw = bus.id_wr[0] && (bus.id_rd0 != '0) &&
                   ((bus.id_use_rs[2] && bus.id_rs1_1 == bus.id_rd0) ||
                    (bus.id_use_rs[3] && bus.id_rs2_1 == bus.id_rd0));
    assign w_waw = (&bus.id_wr) && (bus.id_rd0 == bus.id_rd1) && (bus.id_rd0 != '0);
    assign w_conflict = (&bus.id_valid) &&
                        (w_raw || w_waw || (&bus.id_mem) || (&bus.id_mdu));

    // In SPLIT1 slot0 has already gone; only slot1 can still be hurt by a load.
    assign w_iss0 = (r_state == ST_PAIR) && bus.id_valid[0];
    assign w_iss1 = ((r_state == ST_PAIR) || (r_state == ST_SPLIT1)) && bus.id_valid[1];
    assign w_loaduse =
        (bus.ex_load[0] && (bus.ex_rd0 != '0) && src_hit(bus.ex_rd0, w_iss0, w_iss1)) ||
        (bus.ex_load[1] && (bus.ex_rd1 != '0) && src_hit(bus.ex_rd1, w_iss0, w_iss1));

    assign w_redirect = bus.mispredict || r_flush_pending;

    always_comb begin
        w_next         = r_state;
        w_unicorn      = (r_state == ST_PAIR) ? w_conflict : 1'b1;
        w_idex_flush   = 1'b0;
        w_issue_select = 2'b00;
        w_ifid_hold    = 1'b0;
        w_ifid_flush   = 1'b0;
        if (bus.pipe_stall) begin
            w_ifid_hold = 1'b1;
        end else if (w_redirect) begin
            w_idex_flush   = 1'b1;
            w_issue_select = 2'b11;
            w_ifid_flush   = 1'b1;
            // A flush mid-split leaves the slot1 ID/EX toggle out of phase.
            w_next         = (r_state == ST_SPLIT1) ? ST_DRAIN : ST_PAIR;
        end else begin
            unique case (r_state)
                ST_PAIR: begin
                    if (w_loaduse) begin
                        w_idex_flush   = 1'b1;
                        w_issue_select = 2'b11;
                        w_ifid_hold    = 1'b1;
                    end else if (w_conflict) begin
                        w_ifid_hold = 1'b1;
                        w_next      = ST_SPLIT1;
                    end
                end
                ST_SPLIT1: begin
                    if (w_loaduse) begin
                        w_idex_flush   = 1'b1;
                        w_issue_select = 2'b10;
                        w_ifid_hold    = 1'b1;
                    end else begin
                        w_next = ST_PAIR;
                    end
                end
                ST_DRAIN: w_next = ST_PAIR;
                default:  w_next = ST_PAIR;
            endcase
        end
    end

    // Everything is forced quiet while reset is held.
    assign bus.decode_unicorn = rst_n && w_unicorn;
    assign bus.idex_stall     = rst_n && bus.pipe_stall;
    assign bus.idex_flush     = rst_n && w_idex_flush;
    assign bus.issue_select   = rst_n ? w_issue_select : 2'b00;
    assign bus.ifid_hold      = rst_n && w_ifid_hold;
    assign bus.ifid_flush     = rst_n && w_ifid_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_PAIR;
            r_flush_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            if (bus.pipe_stall) begin
                if (bus.mispredict) r_flush_pending <= 1'b1;
            end else begin
                r_flush_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_issue_pair_ctrl.sv
// Randomized bench for issue_pair_ctrl against a behavioural pairing model.
module tb_issue_pair_ctrl;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    // Model state: waiting to send slot1 of a split pair / realign cycle / hidden redirect.
    bit m_second_half;
    bit m_realign;
    bit m_pending_redirect;

    issue_pair_if #(.REG_AW(AW)) bus ();

    issue_pair_ctrl #(.REG_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        bus.id_valid = 2'b00; bus.id_rd0 = '0; bus.id_rd1 = '0;
        bus.id_rs1_0 = '0; bus.id_rs2_0 = '0; bus.id_rs1_1 = '0; bus.id_rs2_1 = '0;
        bus.id_use_rs = 4'h0; bus.id_wr = 2'b00; bus.id_mem = 2'b00; bus.id_mdu = 2'b00;
        bus.ex_load = 2'b00; bus.ex_rd0 = '0; bus.ex_rd1 = '0;
        bus.pipe_stall = 1'b0; bus.mispredict = 1'b0;
    endtask

    task automatic indep_pair();
        clear_in();
        bus.id_valid = 2'b11; bus.id_wr = 2'b11; bus.id_use_rs = 4'hF;
        bus.id_rd0 = 5'd5; bus.id_rd1 = 5'd9;
        bus.id_rs1_0 = 5'd1; bus.id_rs2_0 = 5'd2;
        bus.id_rs1_1 = 5'd6; bus.id_rs2_1 = 5'd7;
    endtask

    task automatic raw_pair();
        indep_pair();
        bus.id_rs1_1 = 5'd5;
    endtask

    // One cycle: evaluate expectations from current inputs, compare, then advance the model.
    task automatic step();
        logic [AW-1:0] src [4];
        logic [AW-1:0] exrd [2];
        bit conflict, hazard, any_src;
        logic e_uni, e_stall, e_flush, e_hold, e_ifl;
        logic [1:0] e_sel;

        #2;
        src[0] = bus.id_rs1_0; src[1] = bus.id_rs2_0;
        src[2] = bus.id_rs1_1; src[3] = bus.id_rs2_1;
        exrd[0] = bus.ex_rd0;  exrd[1] = bus.ex_rd1;

        conflict = 0;
        if (bus.id_valid == 2'b11) begin
            for (int j = 2; j < 4; j++)
                if (bus.id_use_rs[j] && bus.id_wr[0] && bus.id_rd0 != 0 && src[j] == bus.id_rd0)
                    conflict = 1;
            if (bus.id_wr == 2'b11 && bus.id_rd0 == bus.id_rd1 && bus.id_rd0 != 0) conflict = 1;
            if (bus.id_mem == 2'b11 || bus.id_mdu == 2'b11) conflict = 1;
        end

        hazard = 0;
        for (int k = 0; k < 2; k++) begin
            if (!bus.ex_load[k] || exrd[k] == 0 || m_realign) continue;
            for (int j = 0; j < 4; j++) begin
                any_src = bus.id_valid[j/2] && bus.id_use_rs[j] && src[j] == exrd[k];
                if (any_src && (j >= 2 || !m_second_half)) hazard = 1;
            end
        end

        e_uni = 0; e_stall = 0; e_flush = 0; e_hold = 0; e_ifl = 0; e_sel = 2'b00;
        if (rst_n) begin
            e_uni = (m_second_half || m_realign) ? 1'b1 : conflict;
            if (bus.pipe_stall) begin
                e_stall = 1; e_hold = 1;
            end else if (bus.mispredict || m_pending_redirect) begin
                e_flush = 1; e_sel = 2'b11; e_ifl = 1;
            end else if (!m_realign && hazard) begin
                e_flush = 1; e_hold = 1; e_sel = m_second_half ? 2'b10 : 2'b11;
            end else if (!m_second_half && !m_realign && conflict) begin
                e_hold = 1;
            end
        end

        chk("decode_unicorn", {3'b0, bus.decode_unicorn}, {3'b0, e_uni});
        chk("idex_stall",     {3'b0, bus.idex_stall},     {3'b0, e_stall});
        chk("idex_flush",     {3'b0, bus.idex_flush},     {3'b0, e_flush});
        chk("issue_select",   {2'b0, bus.issue_select},   {2'b0, e_sel});
        chk("ifid_hold",      {3'b0, bus.ifid_hold},      {3'b0, e_hold});
        chk("ifid_flush",     {3'b0, bus.ifid_flush},     {3'b0, e_ifl});

        @(posedge clk);
        if (!rst_n) begin
            m_second_half = 0; m_realign = 0; m_pending_redirect = 0;
        end else if (bus.pipe_stall) begin
            if (bus.mispredict) m_pending_redirect = 1;
        end else if (bus.mispredict || m_pending_redirect) begin
            m_pending_redirect = 0;
            m_realign = m_second_half;
            m_second_half = 0;
        end else if (m_realign) begin
            m_realign = 0;
        end else if (!hazard) begin
            if (m_second_half) m_second_half = 0;
            else if (conflict) m_second_half = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_second_half = 0; m_realign = 0; m_pending_redirect = 0;
        rst_n = 1'b0;
        clear_in();
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;

        indep_pair(); step(); step(); step();
        raw_pair(); step(); step();

        indep_pair(); bus.id_rs2_0 = 5'd8; bus.ex_load = 2'b01; bus.ex_rd0 = 5'd8; step();
        bus.ex_load = 2'b00; step();

        raw_pair(); bus.id_rs1_1 = 5'd3; bus.id_rs2_1 = 5'd5; step();
        bus.ex_load = 2'b01; bus.ex_rd0 = 5'd3; step();
        bus.ex_load = 2'b00; step();

        raw_pair(); step();
        bus.mispredict = 1'b1; step();
        clear_in(); step(); step();

        indep_pair(); bus.pipe_stall = 1'b1; bus.mispredict = 1'b1; step();
        bus.mispredict = 1'b0; step(); step();
        bus.pipe_stall = 1'b0; step(); step();

        raw_pair(); step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; step(); step();

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            bus.id_valid   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
            bus.id_rd0     = 5'($urandom_range(0, 7));
            bus.id_rd1     = 5'($urandom_range(0, 7));
            bus.id_rs1_0   = 5'($urandom_range(0, 7));
            bus.id_rs2_0   = 5'($urandom_range(0, 7));
            bus.id_rs1_1   = 5'($urandom_range(0, 7));
            bus.id_rs2_1   = 5'($urandom_range(0, 7));
            bus.id_use_rs  = 4'($urandom);
            bus.id_wr      = 2'($urandom);
            bus.id_mem     = 2'($urandom);
            bus.id_mdu     = 2'($urandom);
            bus.ex_load    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            bus.ex_rd0     = 5'($urandom_range(0, 7));
            bus.ex_rd1     = 5'($urandom_range(0, 7));
            bus.pipe_stall = ($urandom_range(0, 4) == 0);
            bus.mispredict = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
